// File: rtl/sdram_frame_writer_if.sv
// Host write port between the frame writer (master) and the SDRAM controller (slave).
interface sdram_frame_writer_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned HADDR_WIDTH = 23
);
  logic                   host_wr;
  logic [HADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0]  host_data;
  logic                   host_op_begun;

  modport master (
    output host_wr,
    output host_addr,
    output host_data,
    input  host_op_begun
  );

  modport slave (
    input  host_wr,
    input  host_addr,
    input  host_data,
    output host_op_begun
  );
endinterface

// File: rtl/sdram_frame_writer.sv
// Captures one frame of a non-stallable pixel stream into an elastic FIFO and drains it
// to the SDRAM controller host port as single-word writes at base + frame offset.
module sdram_frame_writer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned HADDR_WIDTH = 23,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FRAME_WORDS = 1228800
) (
  input  logic                         clk_i,
  input  logic                         rst_bi,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [HADDR_WIDTH-1:0]       base_addr_i,
  input  logic                         pix_valid_i,
  input  logic                         pix_sof_i,
  input  logic [DATA_WIDTH-1:0]        pix_data_i,
  sdram_frame_writer_if.master         host,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic                         overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = HADDR_WIDTH + 1;
  localparam int unsigned EW = HADDR_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_WORDS);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [HADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]          in_cnt_q, in_cnt_d;
  logic [CW-1:0]          out_cnt_q, out_cnt_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_done_q, frame_done_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];

  logic                   push_req_s;
  logic                   push_ok_s;
  logic                   drop_s;
  logic                   pop_s;
  logic                   done_s;
  logic                   host_wr_s;
  logic [EW-1:0]          head_s;

  assign head_s    = mem_q[rd_ptr_q];
  assign host_wr_s = (state_q == ST_WRITE) && (level_q != '0);

  // Classify this cycle's pixel and host activity; abort suppresses all of it.
  always_comb begin
    push_req_s = 1'b0;
    if (state_q == ST_ARMED) begin
      push_req_s = pix_valid_i & pix_sof_i;
    end else if (state_q == ST_WRITE) begin
      push_req_s = pix_valid_i & ~pix_sof_i & (in_cnt_q < FRAME_CNT);
    end else begin
      push_req_s = 1'b0;
    end
    pop_s     = host_wr_s & host.host_op_begun & ~abort_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok_s = push_req_s & ~abort_i & ((level_q != FULL_LVL) | pop_s);
    drop_s    = push_req_s & ~abort_i & ~push_ok_s;
  end

  // Next-state and bookkeeping for the capture FSM and FIFO pointers.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    done_s       = 1'b0;
    if (abort_i) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d    = ST_ARMED;
            base_d     = base_addr_i;
            overflow_d = 1'b0;
            in_cnt_d   = '0;
            out_cnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED, ST_WRITE: begin
          if (push_req_s) begin
            in_cnt_d = in_cnt_q + CW'(1'b1);
          end else begin
            in_cnt_d = in_cnt_q;
          end
          wr_ptr_d   = wr_ptr_q + AW'(push_ok_s);
          rd_ptr_d   = rd_ptr_q + AW'(pop_s);
          level_d    = level_q + LW'(push_ok_s) - LW'(pop_s);
          // Drops count as retired so a lossy frame still terminates.
          out_cnt_d  = out_cnt_q + CW'(pop_s) + CW'(drop_s);
          overflow_d = overflow_q | drop_s;
          done_s     = (pop_s | drop_s) && (out_cnt_d == FRAME_CNT);
          if (done_s) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else if ((state_q == ST_ARMED) && push_req_s) begin
            state_d = ST_WRITE;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control registers; everything clears on the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_bi) begin
    if (!rst_bi) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage; each entry carries its frame offset so drops leave address gaps.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= {in_cnt_q[HADDR_WIDTH-1:0], pix_data_i};
    end
  end

  assign host.host_wr   = host_wr_s;
  assign host.host_addr = host_wr_s ? (base_q + head_s[EW-1:DATA_WIDTH]) : '0;
  assign host.host_data = host_wr_s ? head_s[DATA_WIDTH-1:0] : '0;

  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed self-checking bench for sdram_frame_writer (FIFO_DEPTH=4, FRAME_WORDS=8).
module tb_sdram_frame_writer;

  localparam int unsigned DW    = 16;
  localparam int unsigned HW    = 23;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW    = 8;

  logic          clk;
  logic          rst_b;
  logic          start;
  logic          abort;
  logic [HW-1:0] base_addr;
  logic          pix_valid;
  logic          pix_sof;
  logic [DW-1:0] pix_data;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [2:0]    fifo_level;

  int            n_checks;
  int            n_fail;
  int            done_cnt;
  logic [HW-1:0] wa [$];
  logic [DW-1:0] wd [$];

  sdram_frame_writer_if #(.DATA_WIDTH(DW), .HADDR_WIDTH(HW)) hif ();

  sdram_frame_writer #(
    .DATA_WIDTH (DW),
    .HADDR_WIDTH(HW),
    .FIFO_DEPTH (DEPTH),
    .FRAME_WORDS(FW)
  ) dut (
    .clk_i       (clk),
    .rst_bi      (rst_b),
    .start_i     (start),
    .abort_i     (abort),
    .base_addr_i (base_addr),
    .pix_valid_i (pix_valid),
    .pix_sof_i   (pix_sof),
    .pix_data_i  (pix_data),
    .host        (hif),
    .busy_o      (busy),
    .frame_done_o(frame_done),
    .overflow_o  (overflow),
    .fifo_level_o(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller-side log of accepted writes and completion pulses.
  always @(negedge clk) begin
    if (rst_b) begin
      if (hif.host_wr && hif.host_op_begun) begin
        wa.push_back(hif.host_addr);
        wd.push_back(hif.host_data);
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt = 0;
  endtask

  task automatic arm(input logic [HW-1:0] b);
    base_addr = b;
    start     = 1'b1;
    cycle();
    start     = 1'b0;
  endtask

  task automatic push_pix(input logic sof, input logic [DW-1:0] d, input logic op);
    pix_valid         = 1'b1;
    pix_sof           = sof;
    pix_data          = d;
    hif.host_op_begun = op;
    cycle();
    pix_valid         = 1'b0;
    pix_sof           = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    for (int k = 0; k < 64 && done_cnt == 0; k++) cycle();
    ok = (done_cnt != 0);
    for (int k = 0; k < 3; k++) cycle();
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    #1 rst_b = 1'b0;
    #10;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_checks++; if (hif.host_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", hif.host_wr); end
    n_checks++; if (hif.host_addr !== 23'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", hif.host_addr); end
    n_checks++; if (hif.host_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", hif.host_data); end
    #11 rst_b = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    bit ok;
    clear_log();
    hif.host_op_begun = 1'b1;
    arm(23'h100);
    for (int i = 0; i < 10; i++) push_pix(1'b0, 16'hDE00 + 16'(i), 1'b1);
    for (int i = 0; i < 8; i++) push_pix(i == 0, 16'hA000 + 16'(i), 1'b1);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got none want pulse"); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (wa.size() !== 8) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 8", wa.size()); end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== 23'h100 + 23'(i) || wd[i] !== 16'hA000 + 16'(i)) begin
        n_fail++;
        $display("FAIL basic_wr%0d: got %h/%h want %h/%h", i, wa[i], wd[i], 23'h100 + 23'(i), 16'hA000 + 16'(i));
      end
    end
    n_checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy=%b ovf=%b want 0/0", busy, overflow); end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_log();
    arm(23'h200);
    for (int i = 0; i < 8; i++) push_pix(i == 0, 16'hB000 + 16'(i), 1'b0);
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    hif.host_op_begun = 1'b1;
    wait_done(ok);
    n_checks++; if (!ok || done_cnt !== 1) begin n_fail++; $display("FAIL ovf_done: got %0d pulses want 1", done_cnt); end
    n_checks++; if (wa.size() !== 4) begin n_fail++; $display("FAIL ovf_wr_count: got %0d want 4", wa.size()); end
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== 23'h200 + 23'(i) || wd[i] !== 16'hB000 + 16'(i)) begin
        n_fail++;
        $display("FAIL ovf_wr%0d: got %h/%h want %h/%h", i, wa[i], wd[i], 23'h200 + 23'(i), 16'hB000 + 16'(i));
      end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    bit ok;
    clear_log();
    arm(23'h300);
    for (int i = 0; i < 4; i++) push_pix(i == 0, 16'hC000 + 16'(i), 1'b0);
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d want 4", fifo_level); end
    push_pix(1'b0, 16'hC004, 1'b1);
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_pp_level: got %0d want 4", fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovf: got %b want 0", overflow); end
    for (int i = 5; i < 8; i++) push_pix(1'b0, 16'hC000 + 16'(i), 1'b1);
    wait_done(ok);
    n_checks++; if (!ok || done_cnt !== 1) begin n_fail++; $display("FAIL full_done: got %0d pulses want 1", done_cnt); end
    n_checks++; if (wa.size() !== 8) begin n_fail++; $display("FAIL full_wr_count: got %0d want 8", wa.size()); end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== 23'h300 + 23'(i) || wd[i] !== 16'hC000 + 16'(i)) begin
        n_fail++;
        $display("FAIL full_wr%0d: got %h/%h want %h/%h", i, wa[i], wd[i], 23'h300 + 23'(i), 16'hC000 + 16'(i));
      end
    end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf_end: got %b want 0", overflow); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [HW-1:0] exp_a;
    clear_log();
    arm(23'h7FFFFE);
    for (int i = 0; i < 8; i++) push_pix(i == 0, 16'hF000 + 16'(i), 1'b1);
    wait_done(ok);
    n_checks++; if (!ok || wa.size() !== 8) begin n_fail++; $display("FAIL wrap_count: got %0d writes want 8", wa.size()); end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      exp_a = 23'h7FFFFE + 23'(i);
      n_checks++;
      if (wa[i] !== exp_a) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, wa[i], exp_a); end
    end
  endtask

  task automatic test_abort();
    bit ok;
    clear_log();
    arm(23'h400);
    push_pix(1'b1, 16'hD000, 1'b0);
    for (int i = 1; i < 4; i++) push_pix(1'b0, 16'hD000 + 16'(i), 1'b1);
    push_pix(1'b0, 16'hD004, 1'b0);
    n_checks++; if (fifo_level !== 3'd2 || wa.size() !== 3) begin n_fail++; $display("FAIL abort_pre: got level=%0d writes=%0d want 2/3", fifo_level, wa.size()); end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    n_checks++; if (hif.host_wr !== 1'b0) begin n_fail++; $display("FAIL abort_wr: got %b want 0", hif.host_wr); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL abort_level: got %0d want 0", fifo_level); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    for (int i = 0; i < 5; i++) push_pix(1'b0, 16'h5555, 1'b1);
    n_checks++; if (wa.size() !== 3 || done_cnt !== 0) begin n_fail++; $display("FAIL abort_quiet: got writes=%0d done=%0d want 3/0", wa.size(), done_cnt); end
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== 23'h400 + 23'(i) || wd[i] !== 16'hD000 + 16'(i)) begin
        n_fail++;
        $display("FAIL abort_wr%0d: got %h/%h want %h/%h", i, wa[i], wd[i], 23'h400 + 23'(i), 16'hD000 + 16'(i));
      end
    end
    clear_log();
    arm(23'h480);
    for (int i = 0; i < 8; i++) push_pix(i == 0, 16'hE000 + 16'(i), 1'b1);
    wait_done(ok);
    n_checks++; if (!ok || done_cnt !== 1 || wa.size() !== 8) begin n_fail++; $display("FAIL abort_restart: got done=%0d writes=%0d want 1/8", done_cnt, wa.size()); end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== 23'h480 + 23'(i) || wd[i] !== 16'hE000 + 16'(i)) begin
        n_fail++;
        $display("FAIL restart_wr%0d: got %h/%h want %h/%h", i, wa[i], wd[i], 23'h480 + 23'(i), 16'hE000 + 16'(i));
      end
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    clear_log();
    hif.host_op_begun = 1'b0;
    arm(23'h500);
    for (int i = 0; i < 3; i++) push_pix(i == 0, 16'h9000 + 16'(i), 1'b0);
    n_checks++; if (hif.host_wr !== 1'b1 || fifo_level !== 3'd3) begin n_fail++; $display("FAIL midrst_pre: got wr=%b level=%0d want 1/3", hif.host_wr, fifo_level); end
    #3 rst_b = 1'b0;
    #1;
    n_checks++; if (hif.host_wr !== 1'b0 || hif.host_addr !== 23'h0 || hif.host_data !== 16'h0) begin
      n_fail++; $display("FAIL midrst_host: got %b/%h/%h want 0/0/0", hif.host_wr, hif.host_addr, hif.host_data);
    end
    n_checks++; if (busy !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_status: got busy=%b level=%0d ovf=%b done=%b want 0", busy, fifo_level, overflow, frame_done);
    end
    base_addr = 23'h777;
    start     = 1'b1;
    cycle();
    cycle();
    start = 1'b0;
    #2 rst_b = 1'b1;
    cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_start_ignored: got busy=%b want 0", busy); end
    clear_log();
    arm(23'h600);
    for (int i = 0; i < 8; i++) push_pix(i == 0, 16'h6000 + 16'(i), 1'b1);
    wait_done(ok);
    n_checks++; if (!ok || wa.size() !== 8) begin n_fail++; $display("FAIL midrst_recover: got %0d writes want 8", wa.size()); end
    if (wa.size() == 8) begin
      n_checks++; if (wa[0] !== 23'h600 || wa[7] !== 23'h607) begin n_fail++; $display("FAIL midrst_addr: got %h..%h want 600..607", wa[0], wa[7]); end
    end
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    done_cnt          = 0;
    start             = 1'b0;
    abort             = 1'b0;
    base_addr         = '0;
    pix_valid         = 1'b0;
    pix_sof           = 1'b0;
    pix_data          = '0;
    hif.host_op_begun = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_abort();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
